// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer side of the common data bus.
// Each functional unit deposits one result into its own holding register.
// A round-robin scan starting at rr_ptr_r hands up to CDB_WIDTH held results
// per cycle to the broadcast lanes, and the lanes are registered.
// Optional feature macro: CDB_ARB_PERF_EN adds saturating stall and broadcast
// counters. The default build, with the macro undefined, has neither counter.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int PRF_DEPTH = 64,
    parameter int ROB_DEPTH = 32,
    localparam int PRF_IDX_W = $clog2(PRF_DEPTH),
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_FU-1:0]    fu_valid,
    output logic [NUM_FU-1:0]    fu_ready,
    input  logic [PRF_IDX_W-1:0] fu_rd_phy    [NUM_FU],
    input  logic [31:0]          fu_rd_value  [NUM_FU],
    input  logic [ROB_IDX_W-1:0] fu_rob_id    [NUM_FU],
    output logic [CDB_WIDTH-1:0] cdb_valid,
    output logic [PRF_IDX_W-1:0] cdb_rd_phy   [CDB_WIDTH],
    output logic [31:0]          cdb_rd_value [CDB_WIDTH],
    output logic [ROB_IDX_W-1:0] cdb_rob_id   [CDB_WIDTH]
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt [NUM_FU],
    output logic [31:0]          perf_bcast_cnt
`endif
);

    localparam int FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Holding registers, one entry per FU
    logic [NUM_FU-1:0]    hold_valid_r;
    logic [PRF_IDX_W-1:0] hold_rd_phy_r   [NUM_FU];
    logic [31:0]          hold_rd_value_r [NUM_FU];
    logic [ROB_IDX_W-1:0] hold_rob_id_r   [NUM_FU];

    // Round-robin pointer and arbitration results
    logic [FU_IDX_W-1:0]  rr_ptr_r;
    logic [FU_IDX_W-1:0]  rr_next_s;
    logic [FU_IDX_W-1:0]  last_grant_s;
    logic [NUM_FU-1:0]    grant_s;
    logic [CDB_WIDTH-1:0] lane_vld_s;
    logic [FU_IDX_W-1:0]  lane_sel_s [CDB_WIDTH];

    // Round-robin scan over held entries only; lanes are filled lowest-first
    always_comb begin
        int                  pos;
        logic [FU_IDX_W-1:0] idx;
        logic                placed;
        grant_s      = '0;
        lane_vld_s   = '0;
        last_grant_s = rr_ptr_r;
        pos          = 0;
        idx          = '0;
        placed       = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            lane_sel_s[k] = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            pos = int'(rr_ptr_r) + j;
            if (pos >= NUM_FU) begin
                pos = pos - NUM_FU;
            end else begin
                pos = pos;
            end
            idx = FU_IDX_W'(pos);
            if (hold_valid_r[idx]) begin
                placed = 1'b0;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (!placed && !lane_vld_s[k]) begin
                        lane_vld_s[k] = 1'b1;
                        lane_sel_s[k] = idx;
                        placed        = 1'b1;
                    end else begin
                        placed = placed;
                    end
                end
                if (placed) begin
                    grant_s[idx] = 1'b1;
                    last_grant_s = idx;
                end else begin
                    last_grant_s = last_grant_s;
                end
            end else begin
                placed = 1'b0;
            end
        end
    end

    // Next pointer starts just past the last granted FU
    always_comb begin
        rr_next_s = rr_ptr_r;
        if (|grant_s) begin
            if (last_grant_s == FU_IDX_W'(NUM_FU - 1)) begin
                rr_next_s = '0;
            end else begin
                rr_next_s = last_grant_s + FU_IDX_W'(1);
            end
        end else begin
            rr_next_s = rr_ptr_r;
        end
    end

    // A slot accepts when it is empty or is draining to a lane this cycle
    always_comb begin
        fu_ready = '0;
        if (rst || flush) begin
            fu_ready = '0;
        end else begin
            fu_ready = ~hold_valid_r | grant_s;
        end
    end

    // Holding registers: capture on handshake, clear on grant or flush
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_rd_phy_r[i]   <= '0;
                hold_rd_value_r[i] <= 32'h0000_0000;
                hold_rob_id_r[i]   <= '0;
            end
        end else if (flush) begin
            hold_valid_r <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    hold_valid_r[i]    <= 1'b1;
                    hold_rd_phy_r[i]   <= fu_rd_phy[i];
                    hold_rd_value_r[i] <= fu_rd_value[i];
                    hold_rob_id_r[i]   <= fu_rob_id[i];
                end else if (grant_s[i]) begin
                    hold_valid_r[i] <= 1'b0;
                end else begin
                    hold_valid_r[i] <= hold_valid_r[i];
                end
            end
        end
    end

    // Round-robin pointer; a flushed cycle's grants never reach the bus, so it holds
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (flush) begin
            rr_ptr_r <= rr_ptr_r;
        end else begin
            rr_ptr_r <= rr_next_s;
        end
    end

    // Broadcast lanes: granted lanes load the entry, idle lanes keep stale data
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= '0;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_rd_phy[k]   <= '0;
                cdb_rd_value[k] <= 32'h0000_0000;
                cdb_rob_id[k]   <= '0;
            end
        end else if (flush) begin
            cdb_valid <= '0;
        end else begin
            cdb_valid <= lane_vld_s;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                if (lane_vld_s[k]) begin
                    cdb_rd_phy[k]   <= hold_rd_phy_r[lane_sel_s[k]];
                    cdb_rd_value[k] <= hold_rd_value_r[lane_sel_s[k]];
                    cdb_rob_id[k]   <= hold_rob_id_r[lane_sel_s[k]];
                end else begin
                    cdb_rd_phy[k]   <= cdb_rd_phy[k];
                    cdb_rd_value[k] <= cdb_rd_value[k];
                    cdb_rob_id[k]   <= cdb_rob_id[k];
                end
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    localparam int CNT_W = $clog2(NUM_FU + 1);

    logic [CNT_W-1:0] grant_cnt_s;
    logic [32:0]      bcast_sum_s;

    // Grants that actually reach the lanes this cycle (none during flush)
    always_comb begin
        grant_cnt_s = '0;
        if (flush) begin
            grant_cnt_s = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                grant_cnt_s = grant_cnt_s + CNT_W'(grant_s[i]);
            end
        end
        bcast_sum_s = {1'b0, perf_bcast_cnt} + 33'(grant_cnt_s);
    end

    // Saturating counters, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bcast_cnt <= 32'h0000_0000;
            for (int i = 0; i < NUM_FU; i++) begin
                perf_stall_cnt[i] <= 32'h0000_0000;
            end
        end else begin
            if (bcast_sum_s[32]) begin
                perf_bcast_cnt <= 32'hFFFF_FFFF;
            end else begin
                perf_bcast_cnt <= bcast_sum_s[31:0];
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (hold_valid_r[i] && !grant_s[i] && (perf_stall_cnt[i] != 32'hFFFF_FFFF)) begin
                    perf_stall_cnt[i] <= perf_stall_cnt[i] + 32'd1;
                end else begin
                    perf_stall_cnt[i] <= perf_stall_cnt[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (NUM_FU=4, CDB_WIDTH=2).
// Expected broadcasts are pushed to a scoreboard queue in the order the lanes
// should emit them and are popped as valid lanes appear.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  fu_valid;
    logic [3:0]  fu_ready;
    logic [5:0]  fu_rd_phy    [4];
    logic [31:0] fu_rd_value  [4];
    logic [4:0]  fu_rob_id    [4];
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_rd_phy   [2];
    logic [31:0] cdb_rd_value [2];
    logic [4:0]  cdb_rob_id   [2];
`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_stall_cnt [4];
    logic [31:0] perf_bcast_cnt;
`endif

    typedef struct packed {
        logic [5:0]  phy;
        logic [31:0] val;
        logic [4:0]  rob;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    cdb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_rd_phy    (fu_rd_phy),
        .fu_rd_value  (fu_rd_value),
        .fu_rob_id    (fu_rob_id),
        .cdb_valid    (cdb_valid),
        .cdb_rd_phy   (cdb_rd_phy),
        .cdb_rd_value (cdb_rd_value),
        .cdb_rob_id   (cdb_rob_id)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_bcast_cnt (perf_bcast_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fu(input int i, input logic [5:0] phy, input logic [31:0] val,
                            input logic [4:0] rob, input bit push);
        exp_t e;
        fu_valid[i]    = 1'b1;
        fu_rd_phy[i]   = phy;
        fu_rd_value[i] = val;
        fu_rob_id[i]   = rob;
        e.phy = phy;
        e.val = val;
        e.rob = rob;
        if (push) sb.push_back(e);
    endtask

    task automatic check_cycle(input logic [1:0] exp_valid, input string tag);
        exp_t        e;
        logic [42:0] got;
        chk({tag, " valid"}, 64'(cdb_valid), 64'(exp_valid));
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] === 1'b1) begin
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL %s lane%0d: observed unexpected broadcast rob=%0h expected none",
                           tag, k, cdb_rob_id[k]);
                end
                if (sb.size() != 0) begin
                    e   = sb.pop_front();
                    got = {cdb_rd_phy[k], cdb_rd_value[k], cdb_rob_id[k]};
                    chk($sformatf("%s lane%0d fields", tag, k), 64'(got), 64'(e));
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            fu_rd_phy[i]   = 6'd0;
            fu_rd_value[i] = 32'h0000_0000;
            fu_rob_id[i]   = 5'd0;
        end

        // Reset held for two cycles with every FU presenting a result
        for (int i = 0; i < 4; i++) begin
            drive_fu(i, 6'(10 + i), 32'hA000_0000 + 32'(i), 5'(20 + i), 1'b0);
        end
        tick();
        chk("rst1 ready", 64'(fu_ready), 64'h0);
        check_cycle(2'b00, "rst1");
        tick();
        chk("rst2 ready", 64'(fu_ready), 64'h0);
        check_cycle(2'b00, "rst2");
        chk("rst lane0 data", 64'({cdb_rd_phy[0], cdb_rd_value[0], cdb_rob_id[0]}), 64'h0);
        chk("rst lane1 data", 64'({cdb_rd_phy[1], cdb_rd_value[1], cdb_rob_id[1]}), 64'h0);
`ifdef CDB_ARB_PERF_EN
        chk("rst bcast", 64'(perf_bcast_cnt), 64'h0);
`endif

        // Release reset: all four captured at once, contention with rr_ptr=0
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_fu(i, 6'(10 + i), 32'hA000_0000 + 32'(i), 5'(20 + i), 1'b1);
        end
        #1;
        chk("post-rst ready", 64'(fu_ready), 64'hF);
        tick();
        check_cycle(2'b00, "cont e1");
        fu_valid = 4'b0000;
        tick();
        check_cycle(2'b11, "cont e2");
        tick();
        check_cycle(2'b11, "cont e3");
`ifdef CDB_ARB_PERF_EN
        chk("perf stall0", 64'(perf_stall_cnt[0]), 64'd0);
        chk("perf stall2", 64'(perf_stall_cnt[2]), 64'd1);
        chk("perf stall3", 64'(perf_stall_cnt[3]), 64'd1);
        chk("perf bcast", 64'(perf_bcast_cnt), 64'd4);
`endif
        tick();
        check_cycle(2'b00, "cont idle");

        // rr_ptr back at 0: FU0 must take lane0 ahead of FU3
        drive_fu(0, 6'd33, 32'h0000_1111, 5'd7, 1'b1);
        drive_fu(3, 6'd34, 32'h0000_3333, 5'd8, 1'b1);
        tick();
        check_cycle(2'b00, "rr0 e1");
        fu_valid = 4'b0000;
        tick();
        check_cycle(2'b11, "rr0 e2");

        // Single FU2 result, lane1 stays idle
        drive_fu(2, 6'd5, 32'hDEAD_BEEF, 5'd3, 1'b1);
        #1;
        chk("single ready2", 64'(fu_ready[2]), 64'h1);
        tick();
        check_cycle(2'b00, "single e1");
        fu_valid = 4'b0000;
        tick();
        check_cycle(2'b01, "single e2");
        tick();
        check_cycle(2'b00, "single idle");

        // Back-to-back on FU1 for 8 cycles
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive_fu(1, 6'(c + 1), 32'h0000_1000 + 32'(c), 5'(c), 1'b1);
                #1;
                chk($sformatf("b2b ready c%0d", c), 64'(fu_ready[1]), 64'h1);
            end else begin
                fu_valid = 4'b0000;
            end
            tick();
            check_cycle((c >= 1 && c <= 8) ? 2'b01 : 2'b00, $sformatf("b2b c%0d", c));
        end

        // Contention with rr_ptr=2: FU2,FU3 first, then FU0,FU1
        drive_fu(2, 6'd42, 32'h2222_0002, 5'd12, 1'b1);
        drive_fu(3, 6'd43, 32'h2222_0003, 5'd13, 1'b1);
        drive_fu(0, 6'd40, 32'h2222_0000, 5'd10, 1'b1);
        drive_fu(1, 6'd41, 32'h2222_0001, 5'd11, 1'b1);
        tick();
        check_cycle(2'b00, "rr2 e1");
        fu_valid = 4'b0000;
        tick();
        check_cycle(2'b11, "rr2 e2");
        tick();
        check_cycle(2'b11, "rr2 e3");
        tick();
        check_cycle(2'b00, "rr2 idle");

        // Flush with three entries held; inputs during flush must be dropped
        drive_fu(0, 6'd50, 32'hBAD0_0000, 5'd30, 1'b0);
        drive_fu(1, 6'd51, 32'hBAD0_0001, 5'd31, 1'b0);
        drive_fu(2, 6'd52, 32'hBAD0_0002, 5'd29, 1'b0);
        tick();
        check_cycle(2'b00, "fl load");
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_fu(i, 6'd60, 32'hBAD1_0000 + 32'(i), 5'(24 + i), 1'b0);
        end
        #1;
        chk("fl ready", 64'(fu_ready), 64'h0);
        tick();
        check_cycle(2'b00, "fl edge");
        flush    = 1'b0;
        fu_valid = 4'b0000;
        tick();
        check_cycle(2'b00, "fl after1");
        tick();
        check_cycle(2'b00, "fl after2");

        // After flush rr_ptr is still 2: FU2 (rd_phy=0) precedes FU0
        drive_fu(2, 6'd0, 32'h0F0F_0F0F, 5'd1, 1'b1);
        drive_fu(0, 6'd9, 32'h1234_5678, 5'd2, 1'b1);
        tick();
        check_cycle(2'b00, "post-fl e1");
        fu_valid = 4'b0000;
        tick();
        check_cycle(2'b11, "post-fl e2");
        tick();
        check_cycle(2'b00, "post-fl idle");

        chk("scoreboard drained", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
